two_sum_ctrl: RTL and testbench

Streaming two-sum solver that acts as the initiator for the direct-mapped `hashmap` cache; it drives the cache's write, read and clear ports. For each accepted element it looks up the complement `target - num`. On a verified hit it reports the index pair; on a miss it inserts `{num, index}`. It sits between an element stream source and a `hashmap` instance, with KEY_WIDTH=DATA_WIDTH and VALUE_WIDTH=DATA_WIDTH+INDEX_WIDTH.

---
 rtl/two_sum_ctrl.sv | 107 ++++++++++
 tb/tb_two_sum_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/two_sum_ctrl.sv
// Streaming two-sum solver driving a direct-mapped hashmap cache.
// Looks up target-num per element; reports the index pair on a key-verified hit, else inserts {num, index}.
module two_sum_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             target,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  output logic                              out_found,
  output logic [INDEX_WIDTH-1:0]            out_idx0,
  output logic [INDEX_WIDTH-1:0]            out_idx1,
  output logic                              collision_seen,
  output logic                              overflow,
  output logic                              busy,
  output logic [DATA_WIDTH-1:0]             hm_write_key,
  output logic [DATA_WIDTH+INDEX_WIDTH-1:0] hm_write_value,
  output logic                              hm_write_request,
  input  logic                              hm_collision,
  output logic [DATA_WIDTH-1:0]             hm_read_key,
  input  logic [DATA_WIDTH+INDEX_WIDTH-1:0] hm_read_value,
  input  logic                              hm_read_response,
  output logic                              hm_clear_cache
);
  localparam int VALUE_WIDTH = DATA_WIDTH + INDEX_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;

  logic [2:0]             state;
  logic [DATA_WIDTH-1:0]  target_q;
  logic [INDEX_WIDTH-1:0] index;
  logic                   hit;

  assign in_ready       = (state == S_RUN) || (state == S_DRAIN);
  assign busy           = (state != S_IDLE);
  assign out_valid      = (state == S_DONE);
  assign hm_clear_cache = (state == S_CLEAR);

  // The cache indexes by low key bits only, so the stored key must be checked.
  assign hm_read_key = target_q - in_data;
  assign hit = (state == S_RUN) && hm_read_response &&
               (hm_read_value[VALUE_WIDTH-1:INDEX_WIDTH] == hm_read_key);

  assign hm_write_request = (state == S_RUN) && in_valid && !hit;
  assign hm_write_key     = in_data;
  assign hm_write_value   = {in_data, index};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      target_q       <= '0;
      index          <= '0;
      out_found      <= 1'b0;
      out_idx0       <= '0;
      out_idx1       <= '0;
      collision_seen <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          target_q       <= target;
          index          <= '0;
          out_found      <= 1'b0;
          out_idx0       <= '0;
          out_idx1       <= '0;
          collision_seen <= 1'b0;
          overflow       <= 1'b0;
          state          <= S_CLEAR;
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: if (in_valid) begin
          if (hit) begin
            out_found <= 1'b1;
            out_idx0  <= hm_read_value[INDEX_WIDTH-1:0];
            out_idx1  <= index;
            state     <= in_last ? S_DONE : S_DRAIN;
          end else begin
            if (hm_collision) collision_seen <= 1'b1;
            if (in_last) begin
              state <= S_DONE;
            end else if (index == IDX_MAX) begin
              overflow <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        S_DRAIN: if (in_valid && in_last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_two_sum_ctrl.sv
// Bench for two_sum_ctrl with a behavioural 4-slot direct-mapped hashmap (overwrite enabled).
module tb_two_sum_ctrl;
  localparam int DW = 4;
  localparam int IW = 4;
  localparam int VW = DW + IW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, in_last;
  logic [DW-1:0] target, in_data;
  logic          out_valid, out_found, collision_seen, overflow, busy;
  logic [IW-1:0] out_idx0, out_idx1;
  logic [DW-1:0] hm_write_key, hm_read_key;
  logic [VW-1:0] hm_write_value, hm_read_value;
  logic          hm_write_request, hm_collision, hm_read_response, hm_clear_cache;

  always #5 clk = ~clk;

  two_sum_ctrl #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_found(out_found), .out_idx0(out_idx0), .out_idx1(out_idx1),
    .collision_seen(collision_seen), .overflow(overflow), .busy(busy),
    .hm_write_key(hm_write_key), .hm_write_value(hm_write_value),
    .hm_write_request(hm_write_request), .hm_collision(hm_collision),
    .hm_read_key(hm_read_key), .hm_read_value(hm_read_value),
    .hm_read_response(hm_read_response), .hm_clear_cache(hm_clear_cache)
  );

  // Hashmap model: slot = key mod 4, combinational read, write on clk.
  logic [3:0]    hvld;
  logic [VW-1:0] hval [4];
  always_ff @(posedge clk) begin
    if (rst || hm_clear_cache) hvld <= '0;
    else if (hm_write_request) begin
      hvld[hm_write_key[1:0]] <= 1'b1;
      hval[hm_write_key[1:0]] <= hm_write_value;
    end
  end
  assign hm_read_response = hvld[hm_read_key[1:0]];
  assign hm_read_value    = hval[hm_read_key[1:0]];
  assign hm_collision     = hm_write_request && hvld[hm_write_key[1:0]] &&
                            (hval[hm_write_key[1:0]][VW-1:IW] != hm_write_key);

  typedef struct packed {
    logic          found;
    logic [IW-1:0] i0;
    logic [IW-1:0] i1;
    logic          coll;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [DW-1:0]         tgt;
    int                    n;
    logic [19:0][DW-1:0]   d;
    exp_t                  e;
  } vec_t;

  vec_t tbl [$];
  exp_t sb  [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: each result pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got out_valid=1 expected no pulse");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("found", out_found, e.found);
        check("idx0", out_idx0, e.i0);
        check("idx1", out_idx1, e.i1);
        check("collision_seen", collision_seen, e.coll);
        check("overflow", overflow, e.ovf);
      end
    end
  end

  task automatic add(input logic [DW-1:0] tgt, input int n, input logic [3:0] d0, d1, d2, d3,
                     input logic f, input logic [IW-1:0] i0, i1, input logic coll);
    vec_t v;
    v.tgt = tgt; v.n = n; v.d = '0;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.e = '{found: f, i0: i0, i1: i1, coll: coll, ovf: 1'b0};
    tbl.push_back(v);
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    start = 1'b1; target = v.tgt; sb.push_back(v.e);
    @(negedge clk);
    start = 1'b0; target = ~v.tgt;
    check("clear_pulse", hm_clear_cache, 1);
    check("ready_in_clear", in_ready, 0);
    @(negedge clk);
    check("clear_one_cycle", hm_clear_cache, 0);
    check("ready_in_run", in_ready, 1);
    check("no_write_without_valid", hm_write_request, 0);
    for (int k = 0; k < v.n; k++) begin
      in_valid = 1'b1; in_data = v.d[k]; in_last = (k == v.n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("done_latency", out_valid, 1);
    @(negedge clk);
    check("pulse_width", out_valid, 0);
    check("scoreboard_drained", sb.size(), 0);
    check("idle_after_done", busy, 0);
    check("result_held", out_found, v.e.found);
  endtask

  initial begin
    vec_t ov;
    rst = 1'b1; start = 1'b0; target = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_found", out_found, 0);
    check("rst_idx", {out_idx0, out_idx1}, 0);
    check("rst_sticky", {collision_seen, overflow}, 0);
    check("rst_busy", busy, 0);
    check("rst_hm_ctrl", {hm_write_request, hm_clear_cache}, 0);
    rst = 1'b0;

    add(4'd9, 4, 4'd2, 4'd7, 4'd11, 4'd15, 1'b1, 4'd0, 4'd1, 1'b0);
    add(4'd3, 2, 4'd5, 4'd14, 4'd0, 4'd0,  1'b1, 4'd0, 4'd1, 1'b0);
    add(4'd6, 3, 4'd3, 4'd1, 4'd3, 4'd0,   1'b1, 4'd0, 4'd2, 1'b0);
    add(4'd7, 3, 4'd2, 4'd6, 4'd5, 4'd0,   1'b0, 4'd0, 4'd0, 1'b1);
    add(4'd0, 3, 4'd1, 4'd2, 4'd3, 4'd0,   1'b0, 4'd0, 4'd0, 1'b0);
    foreach (tbl[i]) run(tbl[i]);

    // 16 misses without last exhaust the index space; the 17th is drained.
    ov.tgt = 4'd0; ov.n = 17; ov.d = '0;
    for (int k = 0; k < 17; k++) ov.d[k] = 4'd1;
    ov.e = '{found: 1'b0, i0: 4'd0, i1: 4'd0, coll: 1'b0, ovf: 1'b1};
    run(ov);

    // Reset mid-run: two accepts (second one collides), then rst.
    @(negedge clk);
    start = 1'b1; target = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'd2;
    @(negedge clk);
    in_data = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrun_collision", collision_seen, 1);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sticky", {collision_seen, overflow}, 0);
    repeat (3) @(negedge clk);
    check("abort_no_pulse", out_valid, 0);
    check("abort_scoreboard", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1);
  end
endmodule
